// File: rtl/fewcore_pkg.sv
// Shared types for the fewcore hazard scheduler: forwarding selects, FSM states and pipeline slot record.
package fewcore_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_WB = 2'b10
  } fwd_sel_t;

  typedef logic [1:0] state_t;
  localparam state_t RUN   = 2'd0;
  localparam state_t STALL = 2'd1;
  localparam state_t FLUSH = 2'd2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
    logic              br;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A slot supplies a source only if it really writes that register; x0 never hazards.
  function automatic logic slot_match(slot_t s, logic [REG_AW-1:0] src, logic use_src);
    return s.v & s.we & (s.rd == src) & (src != '0) & use_src;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter for scheduler performance monitoring.
module hazard_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 3-stage fewcore: forwarding selects, load-use stalls, branch flush.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_sched
  import fewcore_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_branch,
  input  logic              ex_taken,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_rs1,
  output logic [1:0]        fwd_rs2,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

  slot_t            ex_q, wb_q, id_slot;
  state_t           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic             load_use, br_taken;

  assign id_slot = '{v: id_valid, rd: id_rd, we: id_we, ld: id_is_load, br: id_is_branch};

  // Hazard detection and forwarding; EX result beats WB data, loads in EX cannot forward.
  always_comb begin
    ex_hit1  = slot_match(ex_q, id_rs1, id_use_rs1);
    ex_hit2  = slot_match(ex_q, id_rs2, id_use_rs2);
    wb_hit1  = slot_match(wb_q, id_rs1, id_use_rs1);
    wb_hit2  = slot_match(wb_q, id_rs2, id_use_rs2);
    load_use = id_valid & ex_q.ld & (ex_hit1 | ex_hit2);
    br_taken = ex_taken & ex_q.v & ex_q.br;

    fwd_rs1 = FWD_RF;
    if (ex_hit1 && !ex_q.ld) fwd_rs1 = FWD_EX;
    else if (wb_hit1)        fwd_rs1 = FWD_WB;

    fwd_rs2 = FWD_RF;
    if (ex_hit2 && !ex_q.ld) fwd_rs2 = FWD_EX;
    else if (wb_hit2)        fwd_rs2 = FWD_WB;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state and stall/flush; a taken branch overrides any pending load-use stall.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use) begin
          stall   = 1'b1;
          state_d = STALL;
        end
      end
      STALL: state_d = RUN;
      FLUSH: begin
        flush = 1'b1;
        if (fcnt_q <= FC_W'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (br_taken) begin
      flush = 1'b1;
      stall = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end
  end

  // Pipeline slots: stalled or flushed decode work enters EX as a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= SLOT_EMPTY;
      wb_q <= SLOT_EMPTY;
    end else begin
      wb_q <= ex_q;
      ex_q <= (id_valid && !stall && !flush) ? id_slot : SLOT_EMPTY;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .cnt   (perf_stall_cnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .cnt   (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: in-flight instruction model plus directed scenarios.
module tb_hazard_sched;
  import fewcore_pkg::*;

  localparam int unsigned FC = 2;
  localparam int unsigned CW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, id_is_branch, ex_taken;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              stall, flush;
  logic [1:0]        fwd_rs1, fwd_rs2;
  logic [CW-1:0]     perf_stall_cnt, perf_flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_sched #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_is_load     (id_is_load),
    .id_is_branch   (id_is_branch),
    .ex_taken       (ex_taken),
    .stall          (stall),
    .flush          (flush),
    .fwd_rs1        (fwd_rs1),
    .fwd_rs2        (fwd_rs2),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction in flight one stage ahead and two stages ahead, plus flush cycles owed.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
    bit br;
  } rec_t;

  rec_t    m_ex = '{default: 0};
  rec_t    m_wb = '{default: 0};
  int      flush_left = 0;
  longint  m_stall_n = 0;
  longint  m_flush_n = 0;

  function automatic bit writes(rec_t r, int s);
    return r.v && r.we && (r.rd == s);
  endfunction

  function automatic logic [1:0] src_fwd(int s, bit u);
    if (!u || s == 0) return 2'b00;
    if (writes(m_ex, s) && !m_ex.ld) return 2'b01;
    if (writes(m_wb, s)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_branch();
    return ex_taken && m_ex.v && m_ex.br;
  endfunction

  function automatic bit m_flush();
    return m_branch() || (flush_left > 0);
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = id_valid && m_ex.ld &&
         ((id_use_rs1 && id_rs1 != 0 && writes(m_ex, int'(id_rs1))) ||
          (id_use_rs2 && id_rs2 != 0 && writes(m_ex, int'(id_rs2))));
    return lu && !m_flush();
  endfunction

  function automatic rec_t next_ex();
    rec_t r;
    r = '{default: 0};
    if (id_valid && !m_stall() && !m_flush())
      r = '{v: 1, rd: int'(id_rd), we: id_we, ld: id_is_load, br: id_is_branch};
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ex       <= '{default: 0};
      m_wb       <= '{default: 0};
      flush_left <= 0;
      m_stall_n  <= 0;
      m_flush_n  <= 0;
    end else begin
      m_stall_n  <= m_stall_n + (m_stall() ? 1 : 0);
      m_flush_n  <= m_flush_n + (m_flush() ? 1 : 0);
      m_wb       <= m_ex;
      m_ex       <= next_ex();
      flush_left <= m_branch() ? int'(FC) - 1 : (flush_left > 0 ? flush_left - 1 : 0);
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("stall", stall, m_stall());
    check("flush", flush, m_flush());
    check("fwd_rs1", fwd_rs1, src_fwd(int'(id_rs1), id_use_rs1));
    check("fwd_rs2", fwd_rs2, src_fwd(int'(id_rs2), id_use_rs2));
`ifdef HAZARD_PERF_EN
    check("perf_stall", perf_stall_cnt, m_stall_n);
    check("perf_flush", perf_flush_cnt, m_flush_n);
`else
    check("perf_stall", perf_stall_cnt, 0);
    check("perf_flush", perf_flush_cnt, 0);
`endif
  end

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we, bit ld, bit br, bit tk);
    id_valid     = v;
    id_rs1       = REG_AW'(rs1);
    id_use_rs1   = u1;
    id_rs2       = REG_AW'(rs2);
    id_use_rs2   = u2;
    id_rd        = REG_AW'(rd);
    id_we        = we;
    id_is_load   = ld;
    id_is_branch = br;
    ex_taken     = tk;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_fwd1", fwd_rs1, 2'b00);
    reset = 1'b0;
    tick();

    // add x5 then add x6,x5: EX forward
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    check("t1_fwd_ex", fwd_rs1, 2'b01);
    check("t1_stall", stall, 0);
    tick();
    // add x5, bubble, then read x5 on rs2: WB forward; taken with empty EX ignored
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    idle(); tick();
    drive(1, 0, 1, 5, 1, 7, 1, 0, 0, 1);
    check("t1_fwd_wb", fwd_rs2, 2'b10);
    check("t1_flush_noex", flush, 0);
    tick();
    // rs1 named but unused; taken on a non-branch is ignored
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); tick();
    drive(1, 9, 0, 0, 0, 3, 1, 0, 0, 1);
    check("t1_nouse", fwd_rs1, 2'b00);
    check("t1_flush_nobr", flush, 0);
    tick();

    // lw x7 then add x8,x7: one stall, then WB forward
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    check("t2_stall", stall, 1);
    check("t2_flush", flush, 0);
    tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
    check("t2_unstall", stall, 0);
    check("t2_fwd_wb", fwd_rs1, 2'b10);
    tick();
    drive(1, 8, 1, 0, 0, 4, 1, 0, 0, 0);
    check("t2_add_in_ex", fwd_rs1, 2'b01);
    tick();

    // x0 writes never forward or stall
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    check("t3_fwd1", fwd_rs1, 2'b00);
    check("t3_fwd2", fwd_rs2, 2'b00);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    check("t3_ld_x0", stall, 0);
    tick();

    // taken branch: two flush cycles, killed instructions never reach EX
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 1);
    check("t4_flush0", flush, 1);
    check("t4_stall0", stall, 0);
    tick();
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
    check("t4_flush1", flush, 1);
    tick();
    drive(1, 9, 1, 10, 1, 0, 0, 0, 0, 0);
    check("t4_run", flush, 0);
    check("t4_killed1", fwd_rs1, 2'b00);
    check("t4_killed2", fwd_rs2, 2'b00);
    tick();

    // taken branch-and-load in EX with load-use in decode: flush wins
    drive(1, 0, 0, 0, 0, 11, 1, 1, 1, 0); tick();
    drive(1, 11, 1, 0, 0, 12, 1, 0, 0, 1);
    check("t5_flush", flush, 1);
    check("t5_stall", stall, 0);
    tick();
    idle();
    check("t5_flush2", flush, 1);
    tick();
    idle(); tick();

    // reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0); tick();
    drive(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
    check("t6_stall_pre", stall, 1);
    reset = 1'b1;
    #1;
    check("t6_stall", stall, 0);
    check("t6_fwd", fwd_rs1, 2'b00);
    check("t6_perf_s", perf_stall_cnt, 0);
    check("t6_perf_f", perf_flush_cnt, 0);
    tick();
    idle();
    reset = 1'b0;
    tick();
    drive(1, 12, 1, 0, 0, 13, 1, 0, 0, 0);
    check("t6_post_stall", stall, 0);
    check("t6_post_fwd", fwd_rs1, 2'b00);
    tick();
    idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
